// File: rtl/conv_pkg.sv
// conv_pkg: geometry constants and pixel/window/bundle types shared by the
// window generator, its line ring and the downstream conv+FC top.
package conv_pkg;

    localparam int unsigned IMG_W = 28;            // image width in pixels
    localparam int unsigned IMG_H = 28;            // image height in rows
    localparam int unsigned K     = 3;             // square kernel size
    localparam int unsigned DW    = 8;             // pixel width in bits
    localparam int unsigned OUT_W = IMG_W - K + 1; // windows per output row

    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned ROW_W     = $clog2(IMG_H);
    localparam int unsigned SLOT_W    = $clog2(K);
    localparam int unsigned OUT_IDX_W = $clog2(OUT_W);
    localparam int unsigned TAP_W     = $clog2(K * K);

    typedef logic [DW-1:0]        pixel_t;
    typedef pixel_t [K*K-1:0]     window_t;   // tap index ky*K+kx
    typedef window_t [OUT_W-1:0]  bundle_t;   // one window per output column
    typedef pixel_t [IMG_W-1:0]   line_t;
    typedef line_t [K-1:0]        ring_rows_t;
    typedef logic [COL_W-1:0]     col_t;
    typedef logic [ROW_W-1:0]     row_t;

endpackage

// File: rtl/conv_line_ring.sv
// conv_line_ring: K line buffers of IMG_W pixels used as a ring.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (write slot only)
//   i_wr_en       write i_wr_data into the current slot at column i_wr_col
//   i_wr_col      column of the write
//   i_wr_data     pixel to store
//   i_row_done    rotate the write slot after this cycle's write
//   o_rows        all K lines, oldest first; o_rows[K-1] is the line being written
module conv_line_ring
    import conv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  col_t       i_wr_col,
    input  pixel_t     i_wr_data,
    input  logic       i_row_done,
    output ring_rows_t o_rows
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    ring_rows_t        mem_q, mem_d;
    logic [SLOT_W-1:0] rd_idx;

    always_comb begin
        mem_d  = mem_q;
        slot_d = slot_q;
        if (i_wr_en) begin
            mem_d[slot_q][i_wr_col] = i_wr_data;
        end
        if (i_row_done) begin
            slot_d = (slot_q == SLOT_W'(K - 1)) ? '0 : slot_q + SLOT_W'(1);
        end
    end

    // The slot after the write slot holds the oldest line; walking forward
    // from there ends at the write slot itself.
    always_comb begin
        o_rows = '0;
        rd_idx = '0;
        for (int unsigned ky = 0; ky < K; ky++) begin
            rd_idx     = SLOT_W'((32'(slot_q) + 32'd1 + ky) % K);
            o_rows[ky] = mem_q[rd_idx];
        end
    end

    // Line contents need no reset: rows 0..K-2 of a frame never emit.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
        if (i_rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream of an IMG_W x IMG_H image into
// one bundle of OUT_W KxK windows per completed row r >= K-1.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_pre_valid/o_pre_ready      pixel input handshake, i_pixel in raster order
//   o_post_valid/i_post_ready    bundle output handshake
//   o_window                     OUT_W windows, o_window[c][ky*K+kx]
//   o_row_idx                    output row of the bundle, 0..OUT_W-1
//   o_frame_last                 bundle belongs to the last output row
module conv_window_gen
    import conv_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_pre_valid,
    output logic    o_pre_ready,
    input  pixel_t  i_pixel,
    output logic    o_post_valid,
    input  logic    i_post_ready,
    output bundle_t o_window,
    output row_t    o_row_idx,
    output logic    o_frame_last
);

    col_t       col_q, col_d;
    row_t       row_q, row_d;
    logic       valid_q, valid_d;
    bundle_t    win_q, win_d;
    row_t       row_idx_q, row_idx_d;
    logic       last_q, last_d;

    logic       at_row_end, emit_row, accept, emit;
    ring_rows_t ring_rows;
    pixel_t     px;

    assign at_row_end = (col_q == COL_W'(IMG_W - 1));
    assign emit_row   = (row_q >= ROW_W'(K - 1));

    // Only the emitting pixel must wait for the output bank; earlier pixels of
    // the row overwrite the oldest line, which the bank already holds.
    assign o_pre_ready = !(at_row_end && emit_row && valid_q && !i_post_ready);
    assign accept      = i_pre_valid && o_pre_ready;
    assign emit        = accept && at_row_end && emit_row;

    conv_line_ring u_ring (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (accept),
        .i_wr_col   (col_q),
        .i_wr_data  (i_pixel),
        .i_row_done (accept && at_row_end),
        .o_rows     (ring_rows)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (at_row_end) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // The last pixel of the row is still on i_pixel this cycle, not in the ring.
    always_comb begin
        win_d     = win_q;
        row_idx_d = row_idx_q;
        last_d    = last_q;
        valid_d   = valid_q;
        px        = '0;
        if (emit) begin
            for (int unsigned c = 0; c < OUT_W; c++) begin
                for (int unsigned ky = 0; ky < K; ky++) begin
                    for (int unsigned kx = 0; kx < K; kx++) begin
                        px = ring_rows[SLOT_W'(ky)][COL_W'(c + kx)];
                        if (ky == K - 1 && c + kx == IMG_W - 1) begin
                            px = i_pixel;
                        end
                        win_d[OUT_IDX_W'(c)][TAP_W'(ky * K + kx)] = px;
                    end
                end
            end
            row_idx_d = row_q - ROW_W'(K - 1);
            last_d    = (row_q == ROW_W'(IMG_H - 1));
            valid_d   = 1'b1;
        end else if (valid_q && i_post_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            win_q     <= '0;
            row_idx_q <= '0;
            last_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            win_q     <= win_d;
            row_idx_q <= row_idx_d;
            last_q    <= last_d;
        end
    end

    assign o_post_valid = valid_q;
    assign o_window     = win_q;
    assign o_row_idx    = row_idx_q;
    assign o_frame_last = last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized-stimulus bench for conv_window_gen with an
// image-level reference model and a per-cycle compare process.
module tb_conv_window_gen;
    import conv_pkg::*;

    logic    i_clk = 1'b0;
    logic    i_rst = 1'b1;
    logic    i_pre_valid = 1'b0;
    logic    o_pre_ready;
    pixel_t  i_pixel = '0;
    logic    o_post_valid;
    logic    i_post_ready = 1'b1;
    bundle_t o_window;
    row_t    o_row_idx;
    logic    o_frame_last;

    conv_window_gen dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_pixel      (i_pixel),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_window     (o_window),
        .o_row_idx    (o_row_idx),
        .o_frame_last (o_frame_last)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int n_bundles = 0;
    int n_last = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bundle_t    win;
        logic [4:0] idx;
        logic       last;
    } exp_t;

    exp_t   exp_q[$];
    pixel_t img[IMG_H][IMG_W];
    int     m_col = 0;
    int     m_row = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_bundle(string name, bundle_t act, bundle_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            for (int c = 0; c < OUT_W; c++) begin
                if (act[c] !== exp[c]) begin
                    $display("FAIL %s window[%0d]: got %h expected %h", name, c, act[c], exp[c]);
                    break;
                end
            end
        end
    endfunction

    // Windows of output row r-K+1 straight from the stored image.
    function automatic bundle_t build(int r);
        bundle_t b;
        for (int c = 0; c < OUT_W; c++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    b[c][ky*K+kx] = img[r-K+1+ky][c+kx];
        return b;
    endfunction

    function automatic pixel_t pix_val(int mode, int r, int c);
        case (mode)
            0:       return pixel_t'((r*IMG_W + c) & 255);
            1:       return pixel_t'((r*IMG_W + c + 7) & 255);
            2:       return 8'h11;
            default: return 8'h22;
        endcase
    endfunction

    // Compare process: sample at negedge, inputs are stable for the next edge.
    always @(negedge i_clk) begin
        if (mon_en) begin
            bit exp_valid, exp_ready;
            exp_valid = (exp_q.size() > 0);
            exp_ready = !(m_col == IMG_W-1 && m_row >= K-1 && exp_valid && !i_post_ready);
            chk("post_valid", o_post_valid, exp_valid);
            chk("pre_ready", o_pre_ready, exp_ready);
            if (exp_valid && o_post_valid) begin
                chk_bundle("window", o_window, exp_q[0].win);
                chk("row_idx", o_row_idx, exp_q[0].idx);
                chk("frame_last", o_frame_last, exp_q[0].last);
            end
            if (exp_valid && i_post_ready) begin
                n_bundles++;
                if (exp_q[0].last) n_last++;
                void'(exp_q.pop_front());
            end
            if (i_rst) begin
                exp_q.delete();
                m_col = 0;
                m_row = 0;
            end else if (i_pre_valid && exp_ready) begin
                img[m_row][m_col] = i_pixel;
                if (m_col == IMG_W-1 && m_row >= K-1) begin
                    exp_t e;
                    e.win  = build(m_row);
                    e.idx  = 5'(m_row - (K-1));
                    e.last = (m_row == IMG_H-1);
                    exp_q.push_back(e);
                end
                m_col++;
                if (m_col == IMG_W) begin
                    m_col = 0;
                    m_row = (m_row == IMG_H-1) ? 0 : m_row + 1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_pix(input pixel_t v, input int duty);
        bit hs;
        int tmo;
        while ($urandom_range(99) >= duty) begin
            i_pre_valid = 1'b0;
            @(posedge i_clk); #1;
        end
        i_pre_valid = 1'b1;
        i_pixel     = v;
        tmo = 0;
        forever begin
            @(negedge i_clk);
            hs = o_pre_ready;
            @(posedge i_clk); #1;
            if (hs) break;
            tmo++;
            if (tmo > 1000) begin
                chk("pre_handshake_timeout", 0, 1);
                break;
            end
        end
        i_pre_valid = 1'b0;
    endtask

    task automatic feed(input int mode, input int duty, input int start, input int count);
        for (int i = start; i < start + count; i++)
            send_pix(pix_val(mode, i / IMG_W, i % IMG_W), duty);
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_post_valid) break;
            n++;
            if (n > max_cycles) begin
                chk("post_valid_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pixel_t  lit0[K*K];
        pixel_t  lit25[K*K];
        window_t w;
        bundle_t all22;

        lit0  = '{8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
        lit25 = '{8'd25, 8'd26, 8'd27, 8'd53, 8'd54, 8'd55, 8'd81, 8'd82, 8'd83};

        repeat (2) @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        mon_en = 1'b1;
        @(negedge i_clk);
        chk("reset_post_valid", o_post_valid, 0);
        chk("reset_window", o_window, 0);
        chk("reset_row_idx", o_row_idx, 0);
        chk("reset_frame_last", o_frame_last, 0);
        @(posedge i_clk); #1;

        // Ramp frame, always ready, pinned literal windows of bundle 0.
        n_bundles = 0; n_last = 0;
        feed(0, 100, 0, 3*IMG_W);
        @(negedge i_clk);
        chk("lit_first_valid", o_post_valid, 1);
        for (int j = 0; j < K*K; j++) w[j] = lit0[j];
        chk("lit_win0", o_window[0], w);
        for (int j = 0; j < K*K; j++) w[j] = lit25[j];
        chk("lit_win25", o_window[25], w);
        chk("lit_row_idx0", o_row_idx, 0);
        @(posedge i_clk); #1;
        feed(0, 100, 3*IMG_W, IMG_W*IMG_H - 3*IMG_W);
        drain();
        chk("ramp_bundle_count", n_bundles, 26);
        chk("ramp_last_count", n_last, 1);

        // Downstream stalls 40 cycles after the first bundle.
        n_bundles = 0;
        i_post_ready = 1'b0;
        fork
            feed(0, 100, 0, IMG_W*IMG_H);
            begin
                wait_valid(500);
                repeat (40) @(posedge i_clk);
                @(negedge i_clk);
                chk("stall_pre_ready", o_pre_ready, 0);
                chk("stall_row_idx", o_row_idx, 0);
                @(posedge i_clk); #1;
                i_post_ready = 1'b1;
            end
        join
        drain();
        chk("stall_bundle_count", n_bundles, 26);

        // Ready rises on the same edge as the (3,27) handshake.
        i_post_ready = 1'b0;
        feed(0, 100, 0, 4*IMG_W - 1);
        i_post_ready = 1'b1;
        feed(0, 100, 4*IMG_W - 1, 1);
        @(negedge i_clk);
        chk("same_edge_valid", o_post_valid, 1);
        chk("same_edge_row_idx", o_row_idx, 1);
        @(posedge i_clk); #1;
        feed(0, 100, 4*IMG_W, IMG_W*IMG_H - 4*IMG_W);
        drain();

        // Random input bubbles.
        n_bundles = 0;
        feed(0, 50, 0, IMG_W*IMG_H);
        drain();
        chk("bubble_bundle_count", n_bundles, 26);

        // Reset mid-frame after pixel (10,5).
        feed(1, 100, 0, 10*IMG_W + 6);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midreset_post_valid", o_post_valid, 0);
        chk("midreset_window", o_window, 0);
        chk("midreset_row_idx", o_row_idx, 0);
        chk("midreset_frame_last", o_frame_last, 0);
        @(posedge i_clk); #1;
        n_bundles = 0;
        feed(0, 100, 0, IMG_W*IMG_H);
        drain();
        chk("postreset_bundle_count", n_bundles, 26);

        // Back-to-back constant frames.
        feed(2, 100, 0, IMG_W*IMG_H);
        feed(3, 100, 0, 3*IMG_W);
        @(negedge i_clk);
        for (int c = 0; c < OUT_W; c++)
            for (int j = 0; j < K*K; j++)
                all22[c][j] = 8'h22;
        chk("frame2_valid", o_post_valid, 1);
        chk_bundle("frame2_bundle0", o_window, all22);
        chk("frame2_row_idx", o_row_idx, 0);
        @(posedge i_clk); #1;
        feed(3, 100, 3*IMG_W, IMG_W*IMG_H - 3*IMG_W);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the conv+FC top. Takes a raster pixel stream of a 28x28 8-bit image, one pixel per handshake.
- For each valid output row it emits one bundle of 26 3x3 windows (26x9 bytes), which the conv stage consumes through its pre-side valid/ready.
- Per frame: 26 bundles, matching the 26x26 conv output and the 676-input FC layer.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in rows
- K, 3, kernel size (square)
- DW, 8, pixel width in bits

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_pre_valid  in  1  input pixel valid
- o_pre_ready  out  1  input pixel accepted when i_pre_valid && o_pre_ready
- i_pixel  in  DW  pixel value, raster order
- o_post_valid  out  1  window bundle valid
- i_post_ready  in  1  downstream accepts bundle when o_post_valid && i_post_ready
- o_window  out  [IMG_W-K:0][K*K-1:0] x DW  26x9 windows
- o_row_idx  out  5  output row index of the bundle, 0..25
- o_frame_last  out  1  high with the bundle for output row 25

Behaviour:
- Reset (i_rst high at a clock edge):
  - column and row counters go to 0; o_post_valid=0; o_window=0; o_row_idx=0; o_frame_last=0.
  - Row buffer contents are not cleared and are don't-care.
  - Reset mid-frame abandons the frame; the next accepted pixel is row 0, col 0.
- Storage: K row buffers of IMG_W pixels in a ring, plus one output register bank (o_window).
  - An accepted pixel writes the current ring slot at column col.
  - col wraps IMG_W-1 -> 0 and advances row; row wraps IMG_H-1 -> 0, which starts a new frame.
- Window mapping: o_window[c][ky*K+kx] = pixel(r-K+1+ky, c+kx), for c in 0..25 and ky,kx in 0..2. Here r is the input row just completed.
- Emit event:
  - Trigger: the accepted pixel is col=IMG_W-1 of row r with r>=K-1.
  - On the next edge, the output bank loads the windows for output row r-K+1, including the pixel just accepted, which is forwarded from i_pixel rather than read from the buffer.
  - At that edge: o_post_valid=1, o_row_idx=r-K+1, o_frame_last=(r==IMG_H-1).
  - Latency: 1 cycle from the last-pixel handshake to o_post_valid.
- Rows 0..K-2 of every frame emit nothing. Windows never span frames.
- Output handshake:
  - o_post_valid holds, with o_window/o_row_idx/o_frame_last stable, until i_post_ready is sampled high.
  - After acceptance with no new emit, o_post_valid returns to 0 on the next edge.
- Input flow control:
  - o_pre_ready=0 only when col==IMG_W-1 && row>=K-1 && o_post_valid && !i_post_ready. Otherwise o_pre_ready=1.
  - This path is combinational from i_post_ready.
  - Pixels of a row after emission may be accepted while the bundle is pending, because the oldest ring row is already captured in the output bank.
- Simultaneous events: bundle accepted and new emit on the same edge -> the new bundle loads, o_post_valid stays 1, no bubble.
- Input bubbles (i_pre_valid low) stall the counters only; there is no timeout.
- Width rules: counters are clog2(IMG_W) and clog2(IMG_H) bits; no arithmetic on pixel data.

Decomposition:
- Shared package conv_pkg:
  - IMG_W, IMG_H, K, OUT_W=IMG_W-K+1
  - pixel_t (logic [DW-1:0])
  - window_t (pixel_t [K*K-1:0])
  - bundle_t (window_t [OUT_W-1:0])
  - The conv top uses the same typedefs.
- One sub-module, conv_line_ring: K x IMG_W pixel storage with write-slot rotation, exposing all K rows ordered oldest-first to the window assembly logic.

Test Plan:
- Ramp frame, pixel=(row*28+col)&8'hFF, i_post_ready=1, continuous valid ->
  - first o_post_valid 1 cycle after pixel (2,27);
  - o_window[0]={0,1,2,28,29,30,56,57,58}, o_window[25]={25,26,27,53,54,55,81,82,83};
  - 26 bundles total, o_row_idx 0..25, o_frame_last only on row 25.
- Hold i_post_ready=0 for 40 cycles after the first bundle ->
  - rows 3 col 0..26 accepted, o_pre_ready=0 at (3,27);
  - bundle 0 stable throughout; after release, bundle 1 matches ramp, no pixel lost or duplicated.
- i_post_ready rises on the same edge that (3,27) handshakes ->
  - no stall cycle; bundle 1 loads immediately, o_post_valid stays 1.
- Random i_pre_valid (50% duty) on the ramp frame -> bundle contents identical to the first scenario.
- Assert i_rst for 1 cycle after pixel (10,5) ->
  - o_post_valid=0 next cycle;
  - new frame emits first bundle only after 3 full new rows, with new-frame data only.
- Two back-to-back frames with different constant fills (0x11 then 0x22) ->
  - frame-2 bundle 0 is all 0x22; no bundle mixes frame-1 rows.
